// File: rtl/down_counter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// down_counter_pkg : shared state type and default width for down_counter
// Rev 1.0
// ---------------------------------------------------------------------------
package down_counter_pkg;

  localparam int DC_WIDTH_DEFAULT = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dc_state_t;

endpackage
`default_nettype wire

// File: rtl/down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// down_counter : loadable down-counter/timer with valid/ready load and done
//                pulse; DOWN_COUNTER_AUTORELOAD_EN enables periodic reload
// Rev 1.0
// ---------------------------------------------------------------------------
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_val,
  input  logic             abort,
  output logic [WIDTH-1:0] dat_out,
  output logic             busy,
  output logic             done
);

  dc_state_t        state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             done_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  assign count_d = count_q - WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            count_q  <= load_val;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_q <= load_val;
`endif
            // A zero start value has already expired: signal it without running.
            if (load_val != '0) state_q <= RUN;
            else                done_q  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (enable) begin
            if (count_q == WIDTH'(1)) begin
              done_q  <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              count_q <= reload_q;
`else
              count_q <= '0;
              state_q <= IDLE;
`endif
            end else begin
              count_q <= count_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dat_out    = count_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);
  assign load_ready = (state_q == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_down_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_down_counter : directed vector table plus a done-latency sequence
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_down_counter;

  logic        clk = 1'b0;
  logic        reset, enable, load_valid, abort;
  logic [15:0] load_val;
  logic        load_ready, busy, done;
  logic [15:0] dat_out;

  int total = 0;
  int bad   = 0;

  down_counter #(.WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_val   (load_val),
    .abort      (abort),
    .dat_out    (dat_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        lv;
    logic [15:0] val;
    logic        en;
    logic        ab;
    logic [15:0] e_dat;
    logic        e_busy;
    logic        e_done;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic lv, input logic [15:0] val,
                              input logic en, input logic ab, input logic [15:0] e_dat,
                              input logic e_busy, input logic e_done, input logic e_ready);
    vec_t v;
    v.rst = rst; v.lv = lv; v.val = val; v.en = en; v.ab = ab;
    v.e_dat = e_dat; v.e_busy = e_busy; v.e_done = e_done; v.e_ready = e_ready;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; enable = 1'b0; load_valid = 1'b0; abort = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dat",   -1, dat_out, 16'd0);
    check("rst_ready", -1, 16'(load_ready), 16'd1);
    check("rst_busy",  -1, 16'(busy), 16'd0);
    check("rst_done",  -1, 16'(done), 16'd0);

`ifndef DOWN_COUNTER_AUTORELOAD_EN
    //   rst lv  val en ab  dat busy done ready
    // load 5, enable held high; reload 4 at the edge that ends the done cycle
    add(0, 1,  5, 1, 0,  5, 1, 0, 0);
    add(0, 0,  0, 1, 0,  4, 1, 0, 0);
    add(0, 0,  0, 1, 0,  3, 1, 0, 0);
    add(0, 0,  0, 1, 0,  2, 1, 0, 0);
    add(0, 0,  0, 1, 0,  1, 1, 0, 0);
    add(0, 0,  0, 1, 0,  0, 0, 1, 1);
    add(0, 1,  4, 0, 0,  4, 1, 0, 0);
    // enable toggling, a load request in RUN must be ignored
    add(0, 0,  0, 1, 0,  3, 1, 0, 0);
    add(0, 1,  9, 0, 0,  3, 1, 0, 0);
    add(0, 0,  0, 1, 0,  2, 1, 0, 0);
    add(0, 0,  0, 0, 0,  2, 1, 0, 0);
    add(0, 0,  0, 1, 0,  1, 1, 0, 0);
    add(0, 0,  0, 0, 0,  1, 1, 0, 0);
    add(0, 0,  0, 1, 0,  0, 0, 1, 1);
    add(0, 0,  0, 1, 1,  0, 0, 0, 1);
    // load 3, abort together with enable at the terminal cycle
    add(0, 1,  3, 0, 0,  3, 1, 0, 0);
    add(0, 0,  0, 1, 0,  2, 1, 0, 0);
    add(0, 0,  0, 1, 0,  1, 1, 0, 0);
    add(0, 0,  0, 1, 1,  1, 0, 0, 1);
    add(0, 0,  0, 1, 0,  1, 0, 0, 1);
    // zero load
    add(0, 1,  0, 1, 0,  0, 0, 1, 1);
    add(0, 0,  0, 1, 0,  0, 0, 0, 1);
    // reset mid-run, and reset on the terminal edge drops done
    add(0, 1,  7, 1, 0,  7, 1, 0, 0);
    add(0, 0,  0, 1, 0,  6, 1, 0, 0);
    add(1, 0,  0, 1, 0,  0, 0, 0, 1);
    add(0, 1,  1, 1, 0,  1, 1, 0, 0);
    add(1, 0,  0, 1, 0,  0, 0, 0, 1);
    add(0, 1, 16'hFFFF, 0, 0, 16'hFFFF, 1, 0, 0);
    add(0, 0,  0, 1, 0, 16'hFFFE, 1, 0, 0);
    add(0, 0,  0, 0, 1, 16'hFFFE, 0, 0, 1);
`else
    // reload build: load 2 gives period 2, abort is the only exit
    add(0, 1,  2, 1, 0,  2, 1, 0, 0);
    add(0, 0,  0, 1, 0,  1, 1, 0, 0);
    add(0, 0,  0, 1, 0,  2, 1, 1, 0);
    add(0, 0,  0, 1, 0,  1, 1, 0, 0);
    add(0, 0,  0, 1, 0,  2, 1, 1, 0);
    add(0, 0,  0, 1, 1,  2, 0, 0, 1);
    add(0, 1,  3, 0, 0,  3, 1, 0, 0);
    add(0, 0,  0, 0, 1,  3, 0, 0, 1);
    add(0, 1,  0, 1, 0,  0, 0, 1, 1);
    add(0, 0,  0, 1, 0,  0, 0, 0, 1);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; load_valid = vecs[i].lv; load_val = vecs[i].val;
      enable = vecs[i].en; abort = vecs[i].ab;
      @(posedge clk);
      #1;
      check("dat",   i, dat_out, vecs[i].e_dat);
      check("busy",  i, 16'(busy), 16'(vecs[i].e_busy));
      check("done",  i, 16'(done), 16'(vecs[i].e_done));
      check("ready", i, 16'(load_ready), 16'(vecs[i].e_ready));
    end

    // done latency from the accept edge, bounded
    @(negedge clk);
    reset = 1'b0; abort = 1'b0; enable = 1'b1; load_valid = 1'b1; load_val = 16'd5;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("done_latency", -1, 16'(cnt), 16'd5);
    check("done_dat",     -1, dat_out, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
